// File: rtl/bin2bcd_seq_ctrl.sv
// bin2bcd_seq_ctrl: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   start  conversion request, sampled only while ready
//   bin    WIDTH-bit binary operand, captured on start && ready
//   ready  high in IDLE
//   busy   high in SHIFT
//   done   one-cycle pulse in DONE
//   bcd    4*DIGITS-bit registered result, digit 0 in bits [3:0]
//   blank  DIGITS-bit leading-zero mask, present only with BCD_LZ_BLANK_EN
// Optional feature macro: BCD_LZ_BLANK_EN
module bin2bcd_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_LZ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);

    function automatic bit digits_ok();
        longint unsigned p = 1;
        if (DIGITS >= 10) return 1'b1;
        for (int i = 0; i < DIGITS; i++) p = p * 10;
        return p > ((64'd1 << WIDTH) - 1);
    endfunction

    if (WIDTH < 4 || WIDTH > 32 || !digits_ok()) begin : g_bad_params
        $error("bin2bcd_seq_ctrl: WIDTH must be 4..32 and 10**DIGITS must exceed 2**WIDTH-1");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] opnd;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adj;
    logic [SW-1:0]   nxt;
    logic [CW-1:0]   count;

    // Adjust every digit on the pre-shift scratch, then shift in the operand MSB.
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        assign adj[4*k+:4] = scratch[4*k+:4] >= 4'd5 ? scratch[4*k+:4] + 4'd3 : scratch[4*k+:4];
    end
    assign nxt = {adj[SW-2:0], opnd[WIDTH-1]};

    assign ready = state == IDLE;
    assign busy  = state == SHIFT;
    assign done  = state == DONE;

`ifdef BCD_LZ_BLANK_EN
    // Digit k is blank when it and all digits above it are zero; digit 0 always shows.
    logic [DIGITS-1:0] blank_n;
    always_comb begin
        blank_n = '0;
        for (int k = 1; k < DIGITS; k++) blank_n[k] = (nxt >> (4 * k)) == '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            opnd    <= '0;
            scratch <= '0;
            count   <= '0;
            bcd     <= '0;
`ifdef BCD_LZ_BLANK_EN
            blank   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    opnd    <= bin;
                    scratch <= '0;
                    count   <= CW'(WIDTH - 1);
                    state   <= SHIFT;
                end
                SHIFT: begin
                    scratch <= nxt;
                    opnd    <= {opnd[WIDTH-2:0], 1'b0};
                    if (count == '0) begin
                        state <= DONE;
                        bcd   <= nxt;
`ifdef BCD_LZ_BLANK_EN
                        blank <= blank_n;
`endif
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// tb_bin2bcd_seq_ctrl: directed self-checking bench for bin2bcd_seq_ctrl (WIDTH=8, DIGITS=3).
module tb_bin2bcd_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin = '0;
    logic        ready, busy, done;
    logic [11:0] bcd;
`ifdef BCD_LZ_BLANK_EN
    logic [2:0]  blank;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .ready(ready), .busy(busy), .done(done), .bcd(bcd)
`ifdef BCD_LZ_BLANK_EN
        , .blank(blank)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    function automatic logic [11:0] model(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 40);
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic conv(input logic [7:0] b, input string tag);
        int lat, nb;
        bin = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        chk({tag, "_ready0"}, {31'd0, ready}, 32'd0);
        lat = 0;
        nb = 0;
        while (!done && lat < 20) begin
            if (busy) nb++;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_busy_cycles"}, nb, 8);
        chk({tag, "_bcd"}, {20'd0, bcd}, {20'd0, model(int'(b))});
        tick();
        chk({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int n, prev, nd;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bcd", {20'd0, bcd}, 32'd0);
`ifdef BCD_LZ_BLANK_EN
        chk("rst_blank", {29'd0, blank}, 32'd0);
`endif

        conv(8'd0, "zero");
        conv(8'd255, "max");
        chk("max_bcd_hex", {20'd0, bcd}, 32'h255);
`ifdef BCD_LZ_BLANK_EN
        chk("max_blank", {29'd0, blank}, 32'd0);
`endif

        // Back-to-back over every operand with start held high.
        start = 1'b1;
        prev = -1;
        for (int b = 0; b < 256; b++) begin
            bin = 8'(b);
            wait_done(n);
            chk("exh_bcd", {20'd0, bcd}, {20'd0, model(b)});
            if (prev >= 0) chk("exh_period", cyc - prev, 10);
            prev = cyc;
        end
        start = 1'b0;
        tick();

        // A start during SHIFT is ignored.
        bin = 8'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        bin = 8'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        chk("ign_latency", n, 5);
        chk("ign_bcd", {20'd0, bcd}, 32'h099);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) nd++;
        end
        chk("ign_no_extra_done", nd, 0);

        // Reset mid-conversion aborts and clears the result.
        bin = 8'd173;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bcd", {20'd0, bcd}, 32'd0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        conv(8'd173, "after_abort");
        chk("after_abort_hex", {20'd0, bcd}, 32'h173);

        // Reset wins over start on the same edge.
        rst = 1'b1;
        start = 1'b1;
        bin = 8'd5;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio_ready", {31'd0, ready}, 32'd1);
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rst_prio_idle", {31'd0, ready}, 32'd1);

`ifdef BCD_LZ_BLANK_EN
        conv(8'd7, "blank7");
        chk("blank7_bcd", {20'd0, bcd}, 32'h007);
        chk("blank7", {29'd0, blank}, 32'b110);
        conv(8'd0, "blank0");
        chk("blank0", {29'd0, blank}, 32'b110);
        conv(8'd105, "blank105");
        chk("blank105", {29'd0, blank}, 32'b000);
        conv(8'd42, "blank42");
        chk("blank42", {29'd0, blank}, 32'b100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
- Sequential controller that runs the shift-and-add-3 (double-dabble) binary-to-BCD algorithm one bit per clock.
- Replaces the fully unrolled combinational converter where area matters or the input is wider than 8 bits.
- Sits between a binary producer, such as a counter or ADC sample register, and BCD consumers such as seven-segment display drivers.
- Uses a start/ready/done handshake; the result is registered and held until the next conversion completes.

Parameters:
- WIDTH, 8: binary input width in bits (legal range 4..32).
- DIGITS, 3: number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1. Checked by an elaboration-time assertion.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only while ready=1.
- bin  input  WIDTH  binary operand; captured on the edge where start && ready.
- ready  output  1  high in IDLE only; combinational decode of state.
- busy  output  1  high in SHIFT only.
- done  output  1  one-cycle pulse, high in DONE state.
- bcd  output  4*DIGITS  registered result; digit k occupies bits [4k+3:4k], with digit 0 the least significant.

Behaviour:
- One clock, synchronous active-high reset: clock port clk, reset port rst.
- Reset values: state=IDLE, ready=1, busy=0, done=0, bcd=0. Internal shift, scratch and count registers are cleared.
- FSM states and transitions:
  - IDLE: when start=1, load bin into the operand shift register, clear the scratch BCD register, set count=WIDTH-1, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT, each cycle:
    - For every scratch digit >=5, add 3 to that digit (4-bit, no carry between digits).
    - Then shift the scratch left by 1, taking in the operand MSB; shift the operand left by 1.
    - If count==0, go to DONE and load bcd from the post-shift scratch value. Otherwise decrement count.
  - DONE: done=1 for exactly this one cycle; unconditionally go to IDLE.
- Latency: start sampled at edge N; bcd updates and done rises at edge N+WIDTH; done falls and ready rises at edge N+WIDTH+1.
- Maximum throughput is one conversion per WIDTH+2 cycles.
- start while busy or done: ignored, not queued. bin changes after capture have no effect.
- bcd holds its last value through IDLE and SHIFT. It changes only on entry to DONE or on reset.
- Digit adjust uses the scratch value before the shift of the same cycle, matching the standard double-dabble ordering. With DIGITS sized legally, no digit ever exceeds 9 at DONE.
- Scratch register width is 4*DIGITS. Any bits shifted out of the top are discarded; this is unreachable under a legal DIGITS value.
- Reset mid-conversion: aborts immediately, no done pulse, and bcd is cleared to 0.
- Reset has priority over start on the same edge.

Optional Feature:
- Macro BCD_LZ_BLANK_EN.
- When defined, add output blank [DIGITS-1:0], registered and updated on the same edge as bcd. Bit k=1 iff digit k and every more-significant digit are zero. Bit 0 is forced to 0, so a value of 0 shows a single "0". Reset value is all zeros.
- When not defined, the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then start with bin=8'd0 → done pulse at edge N+8, bcd=12'h000, ready returns at edge N+9.
- bin=8'd255 → bcd=12'h255; busy high for exactly 8 cycles; done high for exactly 1 cycle.
- Exhaustive 0..255, back-to-back (start reasserted as soon as ready) → each bcd matches the decimal digits of bin; period is 10 cycles.
- bin=8'd99, then pulse start again with bin=8'd200 during SHIFT → the second request is ignored; bcd=12'h099; no extra done.
- bin=8'd173, rst asserted for one cycle at edge N+4 → no done; bcd=0; ready=1 at the next cycle; a subsequent conversion of 173 gives 12'h173.
- With BCD_LZ_BLANK_EN and bin=8'd7 → bcd=12'h007, blank=3'b110; with bin=8'd0 → blank=3'b110; with bin=8'd105 → blank=3'b000.
